// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and state encoding for the register dump reader.
package reg_dump_pkg;

  localparam int DUMP_W = 8;
  localparam int DUMP_D = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Output word stream of the dump reader: (index, data) words with a
// valid/ready handshake. The reader is the master, the host/trace sink
// is the slave.
interface reg_dump_reader_if
  import reg_dump_pkg::*;
#(
  parameter int W = DUMP_W,
  parameter int D = DUMP_D
) ();

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [D-1:0] out_idx;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    output out_ready
  );

endinterface

// File: rtl/reg_dump_reader.sv
// Register file dump reader: on a start pulse, walks first_reg..last_reg
// (wrapping modulo 2**D) on the file's read-select port, captures each
// value and streams it out as (index, data) words. Never writes the file.
//
// Optional build macro REG_DUMP_PREFETCH_EN: the next register is
// addressed while a word waits in SEND, so a non-final handshake captures
// the following word at the same edge (1 word per cycle instead of 2).
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int W = DUMP_W,
  parameter int D = DUMP_D
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [D-1:0]        first_reg,
  input  logic [D-1:0]        last_reg,
  output logic                busy,
  output logic                done,
  output logic [D-1:0]        rf_rd_num,
  input  logic [W-1:0]        rf_rd_data,
  reg_dump_reader_if.master   stream
);

  dump_state_t  state_q, state_d;
  logic [D-1:0] ptr_q, ptr_d;
  logic [D-1:0] last_q, last_d;
  logic [D-1:0] idx_q, idx_d;
  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  logic         handshake;
  logic [D-1:0] ptr_next;

  assign handshake = valid_q & stream.out_ready;
  assign ptr_next  = ptr_q + 1'b1;

  // State, pointer and output word registers; reset aborts any dump at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; read-select follows ptr so the file output stays stable.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    idx_d     = idx_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    rf_rd_num = ptr_q;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ptr_d   = first_reg;
          last_d  = last_reg;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        data_d  = rf_rd_data;
        idx_d   = ptr_q;
        valid_d = 1'b1;
        state_d = SEND;
      end

      SEND: begin
`ifdef REG_DUMP_PREFETCH_EN
        rf_rd_num = ptr_next;
`endif
        if (handshake) begin
          if (ptr_q == last_q) begin
            valid_d = 1'b0;
            state_d = DONE;
          end else begin
            ptr_d = ptr_next;
`ifdef REG_DUMP_PREFETCH_EN
            data_d = rf_rd_data;
            idx_d  = ptr_next;
`else
            valid_d = 1'b0;
            state_d = FETCH;
`endif
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy             = busy_q;
  assign stream.out_valid = valid_q;
  assign stream.out_data  = data_q;
  assign stream.out_idx   = idx_q;

endmodule
